// File: rtl/debug_stim_sequencer_if.sv
// ---------------------------------------------------------------------------
// debug_stim_sequencer_if
// Groups the button/switch controls and the processor-facing stimulus
// outputs of debug_stim_sequencer.
//   master : drives soft_rst/start/pause/step, observes the stimulus outputs
//   slave  : the sequencer itself
// Signals:
//   soft_rst, start, pause, step  - control requests (master -> slave)
//   cpu_reset                     - processor reset (slave -> master)
//   ssd_sel[SEL_W-1:0]            - current debug channel
//   led_sel[1:0]                  - current LED view select
//   sample_stb, wrap_pulse        - one-cycle event pulses
//   busy                          - scanning or paused
// ---------------------------------------------------------------------------
interface debug_stim_sequencer_if #(
  parameter int SEL_W = 4
);
  logic             soft_rst;
  logic             start;
  logic             pause;
  logic             step;
  logic             cpu_reset;
  logic [SEL_W-1:0] ssd_sel;
  logic [1:0]       led_sel;
  logic             sample_stb;
  logic             wrap_pulse;
  logic             busy;

  modport master (
    output soft_rst, start, pause, step,
    input  cpu_reset, ssd_sel, led_sel, sample_stb, wrap_pulse, busy
  );

  modport slave (
    input  soft_rst, start, pause, step,
    output cpu_reset, ssd_sel, led_sel, sample_stb, wrap_pulse, busy
  );
endinterface

// File: rtl/debug_stim_sequencer.sv
// ---------------------------------------------------------------------------
// debug_stim_sequencer
// On-board reset/select stimulus for processor_main. Stretches the processor
// reset for RESET_CYCLES clocks, then scans ssd_sel over NUM_CH channels with
// DWELL clocks per channel, optionally advancing led_sel once per full scan.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; aborts everything immediately
//   sif    - debug_stim_sequencer_if.slave (controls in, stimulus out)
// All outputs are registered.
// ---------------------------------------------------------------------------
module debug_stim_sequencer #(
  parameter int         RESET_CYCLES = 10,
  parameter int         SEL_W        = 4,
  parameter int         NUM_CH       = 13,
  parameter int         DWELL        = 1000,
  parameter logic [1:0] LED_DEFAULT  = 2'b01,
  parameter bit         LED_ADVANCE  = 1'b1
) (
  input logic                    clk,
  input logic                    reset,
  debug_stim_sequencer_if.slave  sif
);

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int DWELL_W = $clog2(DWELL);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   CH_LAST    = SEL_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    IDLE     = 2'd1,
    SCAN     = 2'd2,
    PAUSED   = 2'd3
  } state_t;

  state_t              state_r, state_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [DWELL_W-1:0]  dwell_cnt_r, dwell_cnt_s;
  logic [SEL_W-1:0]    ssd_sel_r, ssd_sel_s;
  logic [1:0]          led_sel_r, led_sel_s;
  logic                cpu_reset_r;
  logic                sample_stb_r;
  logic                wrap_pulse_r, wrap_s;
  logic                busy_r;
  logic                adv_s;

  // Next-state, counter and channel-advance decode
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    dwell_cnt_s = dwell_cnt_r;
    adv_s       = 1'b0;

    case (state_r)
      RST_HOLD: begin
        if (sif.soft_rst) begin
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (hold_cnt_r == HOLD_LAST) begin
          state_s    = IDLE;
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_W'(1);
        end
      end

      IDLE: begin
        if (sif.soft_rst) begin
          state_s    = RST_HOLD;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (sif.start) begin
          state_s     = SCAN;
          dwell_cnt_s = {DWELL_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end

      // SCAN and PAUSED share the dwell counter. The edge that releases
      // pause already counts, so the channel keeps exactly DWELL counting
      // edges in total across the pause.
      SCAN, PAUSED: begin
        if (sif.soft_rst) begin
          state_s    = RST_HOLD;
          hold_cnt_s = {HOLD_W{1'b0}};
        end else if (sif.pause) begin
          state_s = PAUSED;
          if ((state_r == PAUSED) && sif.step) begin
            adv_s       = 1'b1;
            dwell_cnt_s = {DWELL_W{1'b0}};
          end else begin
            dwell_cnt_s = dwell_cnt_r;
          end
        end else begin
          state_s = SCAN;
          if (dwell_cnt_r == DWELL_LAST) begin
            adv_s       = 1'b1;
            dwell_cnt_s = {DWELL_W{1'b0}};
          end else begin
            dwell_cnt_s = dwell_cnt_r + DWELL_W'(1);
          end
        end
      end

      default: begin
        state_s    = RST_HOLD;
        hold_cnt_s = {HOLD_W{1'b0}};
      end
    endcase
  end

  // Channel / LED view advance with wrap detection
  always_comb begin
    wrap_s    = adv_s && (ssd_sel_r == CH_LAST);
    ssd_sel_s = ssd_sel_r;
    led_sel_s = led_sel_r;
    if (wrap_s) begin
      ssd_sel_s = {SEL_W{1'b0}};
      if (LED_ADVANCE) begin
        led_sel_s = led_sel_r + 2'd1;
      end else begin
        led_sel_s = led_sel_r;
      end
    end else if (adv_s) begin
      ssd_sel_s = ssd_sel_r + SEL_W'(1);
    end else begin
      ssd_sel_s = ssd_sel_r;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= RST_HOLD;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      dwell_cnt_r  <= {DWELL_W{1'b0}};
      ssd_sel_r    <= {SEL_W{1'b0}};
      led_sel_r    <= LED_DEFAULT;
      cpu_reset_r  <= 1'b1;
      sample_stb_r <= 1'b0;
      wrap_pulse_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_cnt_r   <= hold_cnt_s;
      dwell_cnt_r  <= dwell_cnt_s;
      ssd_sel_r    <= ssd_sel_s;
      led_sel_r    <= led_sel_s;
      cpu_reset_r  <= (state_s == RST_HOLD);
      sample_stb_r <= adv_s;
      wrap_pulse_r <= wrap_s;
      busy_r       <= (state_s == SCAN) || (state_s == PAUSED);
    end
  end

  assign sif.cpu_reset  = cpu_reset_r;
  assign sif.ssd_sel    = ssd_sel_r;
  assign sif.led_sel    = led_sel_r;
  assign sif.sample_stb = sample_stb_r;
  assign sif.wrap_pulse = wrap_pulse_r;
  assign sif.busy       = busy_r;

endmodule

// File: tb/tb_debug_stim_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_stim_sequencer
// Directed stimulus with a strobe scoreboard: the stimulus pushes the cycle,
// channel, wrap flag and LED select it expects for every sample_stb; a
// negedge monitor pops and compares on each strobe or wrap pulse.
// Configuration: RESET_CYCLES=10, NUM_CH=3, DWELL=4, LED_ADVANCE=1.
// ---------------------------------------------------------------------------
module tb_debug_stim_sequencer;

  localparam int RESET_CYCLES = 10;
  localparam int SEL_W        = 4;
  localparam int NUM_CH       = 3;
  localparam int DWELL        = 4;

  typedef struct {
    int cyc;
    int ssd;
    int wrap;
    int led;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t exp_q[$];

  debug_stim_sequencer_if #(.SEL_W(SEL_W)) sif ();

  debug_stim_sequencer #(
    .RESET_CYCLES (RESET_CYCLES),
    .SEL_W        (SEL_W),
    .NUM_CH       (NUM_CH),
    .DWELL        (DWELL),
    .LED_DEFAULT  (2'b01),
    .LED_ADVANCE  (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sif   (sif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int c, input int s, input int w, input int l);
    exp_t e;
    e.cyc  = c;
    e.ssd  = s;
    e.wrap = w;
    e.led  = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Current sample shows cpu_reset high; it stays high for RESET_CYCLES
  // samples in total and drops on the next one.
  task automatic hold_check(input string tag);
    check({tag, "_cpu_on"}, int'(sif.cpu_reset), 1);
    for (int i = 1; i < RESET_CYCLES; i++) begin
      @(negedge clk);
      check({tag, "_cpu_hold"}, int'(sif.cpu_reset), 1);
    end
    @(negedge clk);
    check({tag, "_cpu_off"}, int'(sif.cpu_reset), 0);
    check({tag, "_busy"}, int'(sif.busy), 0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sif.sample_stb || sif.wrap_pulse) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_strobe: stb=%0d wrap=%0d ssd=%0d at cycle %0d, none expected",
                 sif.sample_stb, sif.wrap_pulse, sif.ssd_sel, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("stb_cycle", cyc, e.cyc);
        check("stb_valid", int'(sif.sample_stb), 1);
        check("stb_ssd", int'(sif.ssd_sel), e.ssd);
        check("stb_wrap", int'(sif.wrap_pulse), e.wrap);
        check("stb_led", int'(sif.led_sel), e.led);
      end
    end
  end

  int c;
  int st_ssd  [3] = '{2, 0, 1};
  int st_wrap [3] = '{0, 1, 0};
  int st_led  [3] = '{2, 3, 3};

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    reset        = 1'b1;
    sif.soft_rst = 1'b0;
    sif.start    = 1'b0;
    sif.pause    = 1'b0;
    sif.step     = 1'b0;

    // T1: reset for 3 edges, then the reset stretch
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("t1_ssd", int'(sif.ssd_sel), 0);
    check("t1_led", int'(sif.led_sel), 1);
    check("t1_stb", int'(sif.sample_stb), 0);
    hold_check("t1");

    // T2: scan 0,1,2,0 every DWELL cycles, wrap advances led 01->10
    c = cyc;
    sif.start = 1'b1;
    push(c + 5,  1, 0, 1);
    push(c + 9,  2, 0, 1);
    push(c + 13, 0, 1, 2);
    @(negedge clk);
    sif.start = 1'b0;
    check("t2_busy", int'(sif.busy), 1);

    // T3: pause with dwell_cnt=2, hold 5 edges, release
    wait_until(c + 15);
    sif.pause = 1'b1;
    wait_until(c + 20);
    check("t3_ssd_frozen", int'(sif.ssd_sel), 0);
    check("t3_busy", int'(sif.busy), 1);
    sif.pause = 1'b0;
    push(c + 22, 1, 0, 2);
    wait_until(c + 22);

    // T4: pause at ssd_sel=1, three step pulses -> 2,0,1 with one wrap
    sif.pause = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sif.step = 1'b1;
      push(cyc + 1, st_ssd[k], st_wrap[k], st_led[k]);
      @(negedge clk);
      sif.step = 1'b0;
      @(negedge clk);
    end
    check("t4_ssd_held", int'(sif.ssd_sel), 1);
    check("t4_led", int'(sif.led_sel), 3);
    check("t4_busy", int'(sif.busy), 1);

    // T6: reset while PAUSED with led_sel=11
    reset = 1'b1;
    sif.pause = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("t6_ssd", int'(sif.ssd_sel), 0);
    check("t6_led", int'(sif.led_sel), 1);
    check("t6_stb", int'(sif.sample_stb), 0);
    check("t6_wrap", int'(sif.wrap_pulse), 0);
    check("t6_busy", int'(sif.busy), 0);
    hold_check("t6");

    // T5: soft_rst while scanning at ssd_sel=2
    c = cyc;
    sif.start = 1'b1;
    push(c + 5, 1, 0, 1);
    push(c + 9, 2, 0, 1);
    @(negedge clk);
    sif.start = 1'b0;
    wait_until(c + 10);
    sif.soft_rst = 1'b1;
    @(negedge clk);
    sif.soft_rst = 1'b0;
    check("t5_ssd_kept", int'(sif.ssd_sel), 2);
    check("t5_busy_drop", int'(sif.busy), 0);
    hold_check("t5");
    repeat (8) @(negedge clk);
    check("t5_idle_ssd", int'(sif.ssd_sel), 2);
    check("t5_idle_led", int'(sif.led_sel), 1);
    check("t5_idle_busy", int'(sif.busy), 0);

    check("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
